// File: rtl/regbank_pkg.sv
// Shared defaults and constants for the register bank.
// The optional PC-increment feature is controlled by REGBANK_PC_INC_EN.
package regbank_pkg;

    localparam int DEFAULT_DATA_W   = 16;
    localparam int DEFAULT_NUM_REGS = 8;

    localparam logic [7:0] WR_COUNT_MAX = 8'd255;

    // Index of the register that acts as the program counter.
    function automatic int pc_index(input int num_regs);
        return num_regs - 1;
    endfunction

    localparam int PC_IDX = pc_index(DEFAULT_NUM_REGS);

    typedef enum logic [1:0] {
        WR_NONE,
        WR_ONE,
        WR_MULTI
    } wr_kind_e;

endpackage

// File: rtl/reg_cell.sv
// Single falling-edge register with sync reset, load and increment (load wins).
module reg_cell #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(negedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (inc) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/register_bank.sv
// Register bank with one-hot write port, read mux, conflict flag and write counter.
// Define REGBANK_PC_INC_EN to add the pc_inc port for the top register.
module register_bank
    import regbank_pkg::*;
#(
    parameter  int DATA_W   = DEFAULT_DATA_W,
    parameter  int NUM_REGS = DEFAULT_NUM_REGS,
    localparam int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                         clock,
    input  logic                         reset,
`ifdef REGBANK_PC_INC_EN
    input  logic                         pc_inc,
`endif
    input  logic [NUM_REGS-1:0]          wren,
    input  logic [DATA_W-1:0]            buswire,
    input  logic [SEL_W-1:0]             rd_sel,
    output logic [DATA_W-1:0]            rd_data,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out,
    output logic                         wr_conflict,
    output logic [7:0]                   wr_count
);

    localparam int PC_SEL = pc_index(NUM_REGS);

    logic [DATA_W-1:0] q [NUM_REGS];
    wr_kind_e          wr_kind;
    logic              pc_inc_int;

`ifdef REGBANK_PC_INC_EN
    assign pc_inc_int = pc_inc;
`else
    assign pc_inc_int = 1'b0;
`endif

    always_comb begin
        wr_kind = WR_MULTI;
        if (wren == '0) begin
            wr_kind = WR_NONE;
        end else if ($onehot(wren)) begin
            wr_kind = WR_ONE;
        end
    end

    // A conflicting write is dropped entirely, but the PC increment still applies.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        reg_cell #(.W(DATA_W)) u_cell (
            .clock (clock),
            .reset (reset),
            .load  ((wr_kind == WR_ONE) && wren[i]),
            .inc   (pc_inc_int && (i == PC_SEL)),
            .d     (buswire),
            .q     (q[i])
        );
        assign reg_out[i*DATA_W +: DATA_W] = q[i];
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(rd_sel) == i) begin
                rd_data = q[i];
            end
        end
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            wr_conflict <= 1'b0;
            wr_count    <= '0;
        end else begin
            if (wr_kind == WR_MULTI) begin
                wr_conflict <= 1'b1;
            end
            if ((wr_kind == WR_ONE) && (wr_count != WR_COUNT_MAX)) begin
                wr_count <= wr_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed and random steps against a behavioural model.
module tb_register_bank;

    logic         clock = 1'b1;
    logic         reset;
    logic         pc_inc;
    logic [7:0]   wren;
    logic [15:0]  buswire;
    logic [2:0]   rd_sel;
    logic [15:0]  rd_data;
    logic [127:0] reg_out;
    logic         wr_conflict;
    logic [7:0]   wr_count;

    logic         reset2;
    logic         pc_inc2;
    logic [4:0]   wren2;
    logic [7:0]   bus2;
    logic [2:0]   rd_sel2;
    logic [7:0]   rd_data2;
    logic [39:0]  reg_out2;
    logic         conf2;
    logic [7:0]   cnt2;

    int tests = 0;
    int fails = 0;

    logic [15:0] m [8];
    int          m_cnt;
    bit          m_conf;

    always #5 clock = ~clock;

    register_bank #(.DATA_W(16), .NUM_REGS(8)) dut (
        .clock       (clock),
        .reset       (reset),
`ifdef REGBANK_PC_INC_EN
        .pc_inc      (pc_inc),
`endif
        .wren        (wren),
        .buswire     (buswire),
        .rd_sel      (rd_sel),
        .rd_data     (rd_data),
        .reg_out     (reg_out),
        .wr_conflict (wr_conflict),
        .wr_count    (wr_count)
    );

    register_bank #(.DATA_W(8), .NUM_REGS(5)) dut_small (
        .clock       (clock),
        .reset       (reset2),
`ifdef REGBANK_PC_INC_EN
        .pc_inc      (pc_inc2),
`endif
        .wren        (wren2),
        .buswire     (bus2),
        .rd_sel      (rd_sel2),
        .rd_data     (rd_data2),
        .reg_out     (reg_out2),
        .wr_conflict (conf2),
        .wr_count    (cnt2)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [127:0] flat;
        for (int i = 0; i < 8; i++) flat[i*16 +: 16] = m[i];
        check({tag, " reg_out"}, reg_out, flat);
        check({tag, " rd_data"}, {112'd0, rd_data}, {112'd0, m[rd_sel]});
        check({tag, " wr_count"}, {120'd0, wr_count}, 128'(m_cnt));
        check({tag, " wr_conflict"}, {127'd0, wr_conflict}, {127'd0, m_conf});
    endtask

    // Apply one edge's worth of inputs, advance the model, then compare.
    task automatic step(input string tag, input logic [7:0] w, input logic [15:0] b,
                        input bit pc, input bit rst);
        int  ones;
        bit  pc_eff;
        wren    = w;
        buswire = b;
        pc_inc  = pc;
        reset   = rst;
        @(negedge clock);
        #1;
`ifdef REGBANK_PC_INC_EN
        pc_eff = pc;
`else
        pc_eff = 1'b0;
`endif
        ones = $countones(w);
        if (rst) begin
            for (int i = 0; i < 8; i++) m[i] = '0;
            m_cnt  = 0;
            m_conf = 1'b0;
        end else begin
            if (ones == 1) begin
                for (int i = 0; i < 8; i++) if (w[i]) m[i] = b;
                if (m_cnt < 255) m_cnt++;
            end else if (ones > 1) begin
                m_conf = 1'b1;
            end
            if (pc_eff && !(ones == 1 && w[7])) m[7] = 16'((32'(m[7]) + 1) % 65536);
        end
        rd_sel = 3'($urandom_range(0, 7));
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [7:0] w;
        reset = 1'b1; pc_inc = 1'b0; wren = '0; buswire = '0; rd_sel = '0;
        reset2 = 1'b1; pc_inc2 = 1'b0; wren2 = '0; bus2 = '0; rd_sel2 = '0;
        for (int i = 0; i < 8; i++) m[i] = 'x;
        m_cnt = 0; m_conf = 1'b0;

        step("reset", 8'h00, 16'h0000, 1'b0, 1'b1);

        step("wr_beef", 8'h04, 16'hBEEF, 1'b0, 1'b0);
        rd_sel = 3'd2; #1;
        check("beef rd_data", {112'd0, rd_data}, {112'd0, 16'hBEEF});
        check("beef wr_count", {120'd0, wr_count}, 128'd1);

        step("conflict", 8'h05, 16'h1234, 1'b0, 1'b0);
        check("conflict count", {120'd0, wr_count}, 128'd1);
        check("conflict flag", {127'd0, wr_conflict}, 128'd1);
        step("clean1", 8'h01, 16'h1111, 1'b0, 1'b0);
        step("clean2", 8'h02, 16'h2222, 1'b0, 1'b0);
        step("clean3", 8'h08, 16'h3333, 1'b0, 1'b0);
        check("sticky flag", {127'd0, wr_conflict}, 128'd1);
        step("idle", 8'h00, 16'hDEAD, 1'b0, 1'b0);

`ifdef REGBANK_PC_INC_EN
        step("pc_pre", 8'h80, 16'hFFFF, 1'b0, 1'b0);
        step("pc_wrap", 8'h00, 16'h0000, 1'b1, 1'b0);
        check("pc wrap r7", reg_out[127:112], 128'h0000);
        step("pc_vs_wr", 8'h80, 16'h0040, 1'b1, 1'b0);
        check("pc write wins", reg_out[127:112], 128'h0040);
        step("pc_conflict", 8'h81, 16'h5555, 1'b1, 1'b0);
        check("pc in conflict", reg_out[127:112], 128'h0041);
`endif

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                0:       w = 8'h00;
                1, 2:    w = (8'h01 << $urandom_range(0, 3)) | (8'h10 << $urandom_range(0, 3));
                default: w = 8'h01 << $urandom_range(0, 7);
            endcase
            step("random", w, 16'($urandom), bit'($urandom_range(0, 3) == 0),
                 $urandom_range(0, 29) == 0);
        end

        step("pre_sat_reset", 8'h00, 16'h0000, 1'b0, 1'b1);
        for (int n = 0; n < 260; n++) begin
            step("sat", 8'h01 << (n % 8), 16'(n * 97), 1'b0, 1'b0);
        end
        check("saturated", {120'd0, wr_count}, 128'd255);
        step("sat_reset", 8'h00, 16'h0000, 1'b0, 1'b1);
        check("post reset regs", reg_out, 128'd0);
        check("post reset count", {120'd0, wr_count}, 128'd0);

        step("reset_vs_wr", 8'h01, 16'h7777, 1'b1, 1'b1);
        check("reset wins r0", {112'd0, reg_out[15:0]}, 128'd0);
        step("resume", 8'h01, 16'h7777, 1'b0, 1'b0);
        check("resume r0", {112'd0, reg_out[15:0]}, 128'h7777);

        // Five-register, 8-bit instance.
        reset2 = 1'b0;
        rd_sel2 = 3'd6;
        #1;
        check("small sel6", {120'd0, rd_data2}, 128'd0);
        wren2 = 5'h10; bus2 = 8'hA5;
        @(negedge clock); #1;
        wren2 = '0;
        check("small r4", {120'd0, reg_out2[39:32]}, 128'hA5);
        check("small low", {96'd0, reg_out2[31:0]}, 128'd0);
        rd_sel2 = 3'd4; #1;
        check("small rd4", {120'd0, rd_data2}, 128'hA5);
        rd_sel2 = 3'd5; #1;
        check("small sel5", {120'd0, rd_data2}, 128'd0);
        check("small count", {120'd0, cnt2}, 128'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
